// File: rtl/fft_mag_peak_if.sv
// Stream-in / RAM-write-out bundle for fft_mag_peak.
// slave = block side, master = source/sink side.
interface fft_mag_peak_if #(
  parameter int DW = 16,
  parameter int AW = 13,
  parameter int MW = DW + 1
);
  logic                 source_sop;
  logic                 source_eop;
  logic                 source_valid;
  logic signed [DW-1:0] source_real;
  logic signed [DW-1:0] source_imag;
  logic [AW-1:0]        wr_addr;
  logic [MW-1:0]        wr_data;
  logic                 wren;
  logic [MW-1:0]        peak_mag;
  logic [AW-1:0]        peak_bin;
  logic                 peak_valid;
  logic                 frame_err;

  modport slave (
    input  source_sop, source_eop, source_valid, source_real, source_imag,
    output wr_addr, wr_data, wren, peak_mag, peak_bin, peak_valid, frame_err
  );

  modport master (
    output source_sop, source_eop, source_valid, source_real, source_imag,
    input  wr_addr, wr_data, wren, peak_mag, peak_bin, peak_valid, frame_err
  );
endinterface

// File: rtl/fft_mag_peak.sv
// FFT bin magnitude (sqrt(re^2+im^2)) pipeline with RAM write port and
// per-frame peak search; frame tracking rejects out-of-frame samples.
module fft_mag_peak #(
  parameter int DW   = 16,
  parameter int AW   = 13,
  parameter int SKIP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_mag_peak_if.slave bus
);
  localparam int MW = DW + 1;
  localparam int SW = 2*DW + 1;
  localparam int RW = 2*DW + 3;
  localparam int L  = MW + 2;
  localparam logic [AW:0] SKIP_C = (AW+1)'(SKIP);

  typedef enum logic {IDLE, FRAME} state_t;

  typedef struct packed {
    logic          vld;
    logic          sop;
    logic          eop;
    logic [AW-1:0] bin;
  } side_t;

  // ---------------- framing ----------------
  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_frame_err;
  logic          w_acc;
  logic [AW-1:0] w_bin;
  side_t         w_side;

  assign w_acc = bus.source_valid & (bus.source_sop | (r_state == FRAME));
  assign w_bin = bus.source_sop ? '0 : r_cnt + AW'(1);

  always_comb begin
    w_side     = '0;
    w_side.vld = w_acc;
    w_side.sop = bus.source_sop;
    w_side.eop = bus.source_eop;
    w_side.bin = w_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= bus.source_valid &
                     (bus.source_sop ? (r_state == FRAME) : (r_state == IDLE));
      if (w_acc) begin
        r_cnt   <= w_bin;
        r_state <= bus.source_eop ? IDLE : FRAME;
      end
    end
  end

  // ---------------- sideband shift register ----------------
  side_t r_side [1:L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= L; k++) r_side[k] <= '0;
    end else begin
      r_side[1] <= w_side;
      for (int k = 2; k <= L; k++) r_side[k] <= r_side[k-1];
    end
  end

  // ---------------- squares and sum ----------------
  logic signed [2*DW-1:0] w_re_x, w_im_x, w_p_re, w_p_im;
  logic [2*DW-1:0]        r_sq_re, r_sq_im;
  logic [RW-1:0]          r_rem0;

  assign w_re_x = (2*DW)'(bus.source_real);
  assign w_im_x = (2*DW)'(bus.source_imag);
  assign w_p_re = w_re_x * w_re_x;
  assign w_p_im = w_im_x * w_im_x;

  // Skipped bins are zeroed here so the root stages naturally produce 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq_re <= '0;
      r_sq_im <= '0;
      r_rem0  <= '0;
    end else begin
      r_sq_re <= w_p_re;
      r_sq_im <= w_p_im;
      r_rem0  <= ({1'b0, r_side[1].bin} < SKIP_C) ? '0 :
                 RW'(SW'(r_sq_re) + SW'(r_sq_im));
    end
  end

  // ---------------- restoring square root, one bit per stage ----------------
  // Residual tracks sum - root^2; accepting bit B costs (root<<(B+1)) + 2^(2B).
  for (genvar k = 1; k <= MW; k++) begin : g_sq
    localparam int B = MW - k;
    logic [RW-1:0] w_rin, w_inc;
    logic [MW-1:0] w_qin;
    logic [MW-1:0] r_root;
    logic          w_ge;

    if (k == 1) begin : g_first
      assign w_rin = r_rem0;
      assign w_qin = '0;
    end else begin : g_next
      assign w_rin = g_sq[k-1].g_keep.r_rem;
      assign w_qin = g_sq[k-1].r_root;
    end

    assign w_inc = (RW'(w_qin) << (B+1)) + (RW'(1) << (2*B));
    assign w_ge  = (w_rin >= w_inc);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_root <= '0;
      else        r_root <= w_ge ? (w_qin | (MW'(1) << B)) : w_qin;
    end

    if (k < MW) begin : g_keep
      logic [RW-1:0] r_rem;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rem <= '0;
        else        r_rem <= w_ge ? (w_rin - w_inc) : w_rin;
      end
    end
  end

  // ---------------- output stage and peak search ----------------
  side_t         w_o;
  logic [MW-1:0] w_mag;
  logic          w_cand, w_take;
  logic          w_b_seen, w_n_seen;
  logic [MW-1:0] w_b_max, w_n_max;
  logic [AW-1:0] w_b_bin, w_n_bin;
  logic          r_seen, r_pv;
  logic [MW-1:0] r_max, r_pmag;
  logic [AW-1:0] r_maxbin, r_pbin;

  assign w_o    = r_side[L];
  assign w_mag  = g_sq[MW].r_root;
  assign w_cand = w_o.vld & ({1'b0, w_o.bin} >= SKIP_C);

  // A sop at the output restarts the search; an abandoned frame simply never
  // reaches its eop, so no peak is reported for it.
  always_comb begin
    w_b_seen = w_o.sop ? 1'b0 : r_seen;
    w_b_max  = w_o.sop ? '0   : r_max;
    w_b_bin  = w_o.sop ? '0   : r_maxbin;
    w_take   = w_cand & (!w_b_seen | (w_mag > w_b_max));
    w_n_seen = w_take | w_b_seen;
    w_n_max  = w_take ? w_mag : w_b_max;
    w_n_bin  = w_take ? w_o.bin : w_b_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen   <= 1'b0;
      r_max    <= '0;
      r_maxbin <= '0;
      r_pv     <= 1'b0;
      r_pmag   <= '0;
      r_pbin   <= '0;
    end else begin
      r_pv <= w_o.vld & w_o.eop;
      if (w_o.vld) begin
        r_seen   <= w_n_seen;
        r_max    <= w_n_max;
        r_maxbin <= w_n_bin;
        if (w_o.eop) begin
          r_pmag <= w_n_max;
          r_pbin <= w_n_bin;
        end
      end
    end
  end

  assign bus.wren       = w_o.vld;
  assign bus.wr_addr    = w_o.bin;
  assign bus.wr_data    = w_mag;
  assign bus.peak_valid = r_pv;
  assign bus.peak_mag   = r_pmag;
  assign bus.peak_bin   = r_pbin;
  assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_fft_mag_peak.sv
// Bench for fft_mag_peak: a table of magnitude vectors, directed framing
// sequences and random frames, all checked against a cycle-slot scoreboard.
module tb_fft_mag_peak;
  localparam int DW   = 16;
  localparam int AW   = 13;
  localparam int SKIP = 3;
  localparam int MW   = DW + 1;
  localparam int L    = MW + 2;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_mag_peak_if #(.DW(DW), .AW(AW)) bus ();
  fft_mag_peak #(.DW(DW), .AW(AW), .SKIP(SKIP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0, fails = 0;
  int pc = 0;

  // Expected output per cycle slot (slot = number of rising edges seen).
  bit exp_wren [MAXC];
  int exp_addr [MAXC];
  int exp_data [MAXC];
  bit exp_pv   [MAXC];
  int exp_pm   [MAXC];
  int exp_pb   [MAXC];
  bit exp_fe   [MAXC];
  int obs      [64];

  // Model state
  bit      m_open = 0;
  int      m_bin  = 0;
  longint  q_mag [$];
  int      q_bin [$];

  typedef struct { int re; int im; int mag; } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (slot %0d)", nm, act, exp, pc);
    end
  endtask

  function automatic longint isqrt(input longint s);
    longint r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic model(input bit v, input bit s, input bit e, input int re, input int im);
    int n = pc;
    longint mag, pm;
    int pb;
    bit found;
    if (!v) return;
    if (s) begin
      if (m_open && n + 1 < MAXC) exp_fe[n+1] = 1;
      m_open = 1; m_bin = 0;
      q_mag.delete(); q_bin.delete();
    end else if (m_open) begin
      m_bin = (m_bin + 1) % (1 << AW);
    end else begin
      if (n + 1 < MAXC) exp_fe[n+1] = 1;
      return;
    end
    mag = (m_bin < SKIP) ? 0 : isqrt(longint'(re) * re + longint'(im) * im);
    if (n + L < MAXC) begin
      exp_wren[n+L] = 1; exp_addr[n+L] = m_bin; exp_data[n+L] = int'(mag);
    end
    if (m_bin >= SKIP) begin q_mag.push_back(mag); q_bin.push_back(m_bin); end
    if (e) begin
      found = 0; pm = 0; pb = 0;
      foreach (q_mag[i])
        if (!found || q_mag[i] > pm || (q_mag[i] == pm && q_bin[i] < pb)) begin
          found = 1; pm = q_mag[i]; pb = q_bin[i];
        end
      if (n + L + 1 < MAXC) begin
        exp_pv[n+L+1] = 1; exp_pm[n+L+1] = int'(pm); exp_pb[n+L+1] = pb;
      end
      m_open = 0;
    end
  endtask

  task automatic drv(input bit v, input bit s, input bit e, input int re, input int im);
    @(negedge clk);
    bus.source_valid = v;
    bus.source_sop   = s;
    bus.source_eop   = e;
    bus.source_real  = re[DW-1:0];
    bus.source_imag  = im[DW-1:0];
    model(v, s, e, re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.source_valid = 0; bus.source_sop = 0; bus.source_eop = 0;
    rst_n = 0;
    #1;
    chk("rst_wren", bus.wren, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_peak_valid", bus.peak_valid, 0);
    chk("rst_peak_mag", bus.peak_mag, 0);
    chk("rst_peak_bin", bus.peak_bin, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    for (int i = pc + 1; i < MAXC; i++) begin
      exp_wren[i] = 0; exp_pv[i] = 0; exp_fe[i] = 0;
    end
    m_open = 0; m_bin = 0; q_mag.delete(); q_bin.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic int rv();
    logic [15:0] t;
    t = 16'($urandom);
    if ($urandom_range(0, 3) == 0) return int'($signed(t));
    return int'($urandom_range(0, 16)) - 8;
  endfunction

  // Scoreboard: checks every cycle slot just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      pc++;
      #1;
      if (pc < MAXC) begin
        chk("wren", bus.wren, exp_wren[pc]);
        if (exp_wren[pc]) begin
          chk("wr_addr", bus.wr_addr, exp_addr[pc]);
          chk("wr_data", bus.wr_data, exp_data[pc]);
        end
        if (bus.wren && bus.wr_addr < 64) obs[bus.wr_addr] = int'(bus.wr_data);
        chk("peak_valid", bus.peak_valid, exp_pv[pc]);
        if (exp_pv[pc]) begin
          chk("peak_mag", bus.peak_mag, exp_pm[pc]);
          chk("peak_bin", bus.peak_bin, exp_pb[pc]);
        end
        chk("frame_err", bus.frame_err, exp_fe[pc]);
      end
    end
  end

  initial begin
    int len, errpos;
    int a_exp [8];
    tbl[0]  = '{3, 4, 0};          tbl[1]  = '{100, 0, 0};
    tbl[2]  = '{-5, 12, 0};        tbl[3]  = '{3, 4, 5};
    tbl[4]  = '{-5, 12, 13};       tbl[5]  = '{0, 0, 0};
    tbl[6]  = '{-32768, -32768, 46340};
    tbl[7]  = '{32767, 0, 32767};  tbl[8]  = '{-32768, 0, 32768};
    tbl[9]  = '{1, 1, 1};          tbl[10] = '{32767, 32767, 46339};
    tbl[11] = '{7, 24, 25};        tbl[12] = '{2, 3, 3};
    tbl[13] = '{-1000, -1000, 1414};
    tbl[14] = '{12, -5, 13};
    a_exp = '{0, 0, 0, 5, 5, 5, 5, 5};

    rst_n = 0;
    bus.source_valid = 0; bus.source_sop = 0; bus.source_eop = 0;
    bus.source_real = '0; bus.source_imag = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    idle(2);

    // Eight-sample constant frame
    for (int i = 0; i < 64; i++) obs[i] = -1;
    for (int i = 0; i < 8; i++) drv(1, i == 0, i == 7, 3, 4);
    idle(L + 3);
    for (int i = 0; i < 8; i++) chk("A_wr_data", obs[i], a_exp[i]);
    chk("A_peak_mag", bus.peak_mag, 5);
    chk("A_peak_bin", bus.peak_bin, 3);

    // Magnitude table as one frame
    for (int i = 0; i < 64; i++) obs[i] = -1;
    for (int i = 0; i < 15; i++) drv(1, i == 0, i == 14, tbl[i].re, tbl[i].im);
    idle(L + 3);
    for (int i = 0; i < 15; i++) chk("tbl_mag", obs[i], tbl[i].mag);
    chk("tbl_peak_bin", bus.peak_bin, 6);

    // Full-scale corner at bin 10
    for (int i = 0; i < 12; i++)
      if (i == 10) drv(1, 0, 0, -32768, -32768);
      else drv(1, i == 0, i == 11, 1, 1);
    idle(L + 3);
    chk("fs_peak_mag", bus.peak_mag, 46340);
    chk("fs_peak_bin", bus.peak_bin, 10);

    // Gaps between samples
    for (int i = 0; i < 8; i++) begin drv(1, i == 0, i == 7, i, 2 * i); idle(1); end
    idle(L + 3);

    // sop at bin 5 of an open frame
    for (int i = 0; i < 5; i++) drv(1, i == 0, 0, 9, 9);
    for (int i = 0; i < 6; i++) drv(1, i == 0, i == 5, i + 1, 0);
    idle(L + 3);
    chk("restart_peak_bin", bus.peak_bin, 5);

    // Ties: magnitude 7 at bins 4 and 6
    for (int i = 0; i < 8; i++)
      if (i == 4) drv(1, 0, 0, 7, 0);
      else if (i == 6) drv(1, 0, 0, 0, 7);
      else drv(1, i == 0, i == 7, 1, 0);
    idle(L + 3);
    chk("tie_peak_bin", bus.peak_bin, 4);

    // One-sample frame in a skipped bin reports zero peak
    drv(1, 1, 1, 100, 100);
    idle(L + 3);
    chk("empty_peak_mag", bus.peak_mag, 0);
    chk("empty_peak_bin", bus.peak_bin, 0);

    // Reset at bin 4, then a stray sample and a fresh frame
    for (int i = 0; i < 4; i++) drv(1, i == 0, 0, 3, 4);
    pulse_reset();
    drv(1, 0, 0, 3, 4);
    idle(L + 3);
    for (int i = 0; i < 5; i++) drv(1, i == 0, i == 4, 6, 8);
    idle(L + 3);

    // Random frames with stray samples, gaps and restarts
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) drv(1, 0, 0, rv(), rv());
      len = $urandom_range(1, 16);
      errpos = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len) : -1;
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0) idle(1);
        drv(1, (i == 0) || (i == errpos), i == len - 1, rv(), rv());
      end
      idle($urandom_range(0, 3));
    end
    idle(L + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_mag_peak.md
FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning FFT output component width (signed two's complement).
REQ-002 The block SHALL have parameter AW, default 13, meaning bin-index / write-address width (frame length up to 2^AW).
REQ-003 The block SHALL have parameter SKIP, default 3, meaning the number of leading bins (0..SKIP-1) forced to zero and excluded from peak search.
REQ-004 The block SHALL have derived localparam MW = DW+1, meaning magnitude width.
REQ-005 The block SHALL have port clk  in  1  system clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset; reset is asynchronous and active-low.
REQ-007 The block SHALL have port source_sop  in  1  first sample of frame, qualified by source_valid.
REQ-008 The block SHALL have port source_eop  in  1  last sample of frame, qualified by source_valid.
REQ-009 The block SHALL have port source_valid  in  1  sample strobe; no backpressure.
REQ-010 The block SHALL have ports source_real and source_imag  in  DW each  signed FFT components.
REQ-011 The block SHALL have port wr_addr  out  AW  bin index of wr_data.
REQ-012 The block SHALL have port wr_data  out  MW  magnitude for RAM write.
REQ-013 The block SHALL have port wren  out  1  RAM write strobe.
REQ-014 The block SHALL have ports peak_mag  out  MW, peak_bin  out  AW, and peak_valid  out  1 (one-cycle pulse), meaning per-frame maximum.
REQ-015 The block SHALL have port frame_err  out  1  one-cycle pulse on framing violation.

Function
REQ-016 Stage 1 SHALL register re^2 and im^2 (signed squares, 2*DW bits, unsigned result).
REQ-017 Stage 2 SHALL register their sum at 2*DW+1 bits; no truncation.
REQ-018 Stages 3..MW+2 SHALL be a fully pipelined restoring integer square root, one result bit per stage, giving floor(sqrt(sum)) on MW bits.
REQ-019 Total latency L = MW+2 cycles (19 at defaults) from an accepted sample to its wren; throughput SHALL be one sample per cycle and gaps in source_valid SHALL be preserved.
REQ-020 Valid, bin index and eop flags SHALL travel through the pipeline alongside the data; the pipeline never stalls.
REQ-021 The bin counter SHALL be 0 for a valid sample with source_sop, otherwise the previous index +1, wrapping from 2^AW-1 to 0.
REQ-022 A valid sample arriving while no frame is open and without source_sop SHALL be dropped (no wren) and SHALL pulse frame_err.
REQ-023 The state machine SHALL have states IDLE and FRAME: IDLE->FRAME on valid sop; FRAME->IDLE on valid eop; valid sop&eop together SHALL form a one-sample frame.
REQ-024 A valid sop while in FRAME SHALL pulse frame_err, abandon the current peak search without peak_valid, and restart at bin 0.
REQ-025 wren SHALL equal the delayed valid; wr_addr SHALL equal the delayed bin index.
REQ-026 wr_data SHALL be 0 for bins < SKIP and the computed magnitude otherwise.
REQ-027 The peak search SHALL consider only bins >= SKIP, keep the strictly greater magnitude, and resolve ties to the lower bin.
REQ-028 The running maximum SHALL be cleared when the sop sample reaches the output stage.
REQ-029 peak_valid SHALL pulse in the cycle after the eop sample's wren; peak_mag and peak_bin SHALL update in that same cycle and hold until the next peak_valid.
REQ-030 If no bin >= SKIP occurred in the frame, the block SHALL report peak_mag=0 and peak_bin=0.

Reset
REQ-031 On rst_n low, all pipeline registers, the counter, and the state SHALL clear immediately to IDLE, and all outputs SHALL go to 0.
REQ-032 A reset mid-frame SHALL discard in-flight samples, with no wren or peak_valid for them after release.
REQ-033 The first valid sample after release SHALL be treated per REQ-022/023.

Verification
REQ-034 Scenario: frame of 8 samples with re=3, im=4 each -> wren at cycles L..L+7, wr_addr 0..7, wr_data 0,0,0,5,5,5,5,5; peak_valid, peak_mag=5, peak_bin=3.
REQ-035 Scenario: re=im=-32768 at bin 10 -> wr_data=46340, and that sample is the peak.
REQ-036 Scenario: frame with one idle cycle between each sample -> wren pattern identical with gaps preserved, and correct addresses.
REQ-037 Scenario: sop at bin 5 of an open frame -> frame_err pulse, no peak_valid for the first frame, and the second frame indexed from 0.
REQ-038 Scenario: rst_n low for 1 cycle at bin 4 of an 8-bin frame -> outputs 0, no further wren until the next sop.
REQ-039 Scenario: equal magnitude 7 at bins 4 and 6 -> peak_bin=4.
